// File: rtl/note_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : note_scheduler
// Brief    : Rhythm-game beat sequencer. Steps through a song of NUM_BEATS
//            beats, opens a per-lane hit window in each beat, and scores
//            the lane hits at the end of every beat.
// Revision : 1.0 - initial release
// ============================================================================
module note_scheduler #(
  parameter int LANES     = 4,
  parameter int BEAT_CYC  = 25000000,
  parameter int WIN_CYC   = 12500000,
  parameter int NUM_BEATS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [LANES-1:0] note_req,
  input  logic [LANES-1:0] lane_hit,
  output logic [5:0]       beat_idx,
  output logic             tick_out,
  output logic [LANES-1:0] should_hit,
  output logic [11:0]      score,
  output logic [7:0]       combo,
  output logic             busy,
  output logic             done
);

  localparam int CYC_W = $clog2(BEAT_CYC);
  localparam int CNT_W = $clog2(LANES + 1);

  localparam logic [CYC_W-1:0] C_CYC_LAST  = CYC_W'(BEAT_CYC - 1);
  localparam logic [CYC_W-1:0] C_WIN_END   = CYC_W'(WIN_CYC);
  localparam logic [5:0]       C_BEAT_LAST = 6'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CYC_W-1:0] r_cyc, w_cyc_nxt;
  logic [LANES-1:0] r_pattern, w_pattern_nxt;
  logic [5:0]       r_beat, w_beat_nxt;
  logic [11:0]      r_score, w_score_nxt;
  logic [7:0]       r_combo, w_combo_nxt;
  logic             r_tick, r_busy, r_done;

  logic [CNT_W-1:0] w_hits, w_misses;
  logic [12:0]      w_score_sum;
  logic [8:0]       w_combo_sum;

  // Count hit and missed lanes among the notes latched for this beat.
  always_comb begin
    w_hits   = '0;
    w_misses = '0;
    for (int i = 0; i < LANES; i++) begin
      w_hits   = w_hits   + CNT_W'(r_pattern[i] &  lane_hit[i]);
      w_misses = w_misses + CNT_W'(r_pattern[i] & ~lane_hit[i]);
    end
  end

  // One extra bit on each sum so saturation can be detected.
  assign w_score_sum = {1'b0, r_score} + 13'(w_hits);
  assign w_combo_sum = {1'b0, r_combo} + 9'(w_hits);

  // Next-state logic: song control, beat counter, judgement.
  always_comb begin
    w_state_nxt   = r_state;
    w_cyc_nxt     = r_cyc;
    w_pattern_nxt = r_pattern;
    w_beat_nxt    = r_beat;
    w_score_nxt   = r_score;
    w_combo_nxt   = r_combo;
    if (stop) begin
      // Abort: the partial beat is dropped, score and combo are kept.
      w_state_nxt = S_IDLE;
      w_cyc_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_state_nxt = S_PLAY;
            w_cyc_nxt   = '0;
            w_beat_nxt  = '0;
            w_score_nxt = '0;
            w_combo_nxt = '0;
          end
        end
        S_PLAY: begin
          if (r_cyc == '0) begin
            w_pattern_nxt = note_req;
          end
          if (r_cyc == C_CYC_LAST) begin
            w_cyc_nxt   = '0;
            w_score_nxt = (w_score_sum > 13'd4095) ? 12'hFFF : w_score_sum[11:0];
            if (w_misses != '0) begin
              w_combo_nxt = '0;
            end else begin
              w_combo_nxt = (w_combo_sum > 9'd255) ? 8'hFF : w_combo_sum[7:0];
            end
            if (r_beat == C_BEAT_LAST) begin
              w_state_nxt = S_DONE;
            end else begin
              w_beat_nxt = r_beat + 6'd1;
            end
          end else begin
            w_cyc_nxt = r_cyc + CYC_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; status flags are derived from next state
  // so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cyc     <= '0;
      r_pattern <= '0;
      r_beat    <= '0;
      r_score   <= '0;
      r_combo   <= '0;
      r_tick    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cyc     <= w_cyc_nxt;
      r_pattern <= w_pattern_nxt;
      r_beat    <= w_beat_nxt;
      r_score   <= w_score_nxt;
      r_combo   <= w_combo_nxt;
      r_tick    <= (w_state_nxt == S_PLAY) && (w_cyc_nxt == '0);
      r_busy    <= (w_state_nxt == S_PLAY);
      r_done    <= (w_state_nxt == S_DONE);
    end
  end

  // Hit window decoded from registered counter and pattern only.
  assign should_hit = ((r_state == S_PLAY) && (r_cyc != '0) && (r_cyc <= C_WIN_END))
                      ? r_pattern : '0;

  assign beat_idx = r_beat;
  assign tick_out = r_tick;
  assign score    = r_score;
  assign combo    = r_combo;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_note_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_scheduler
// Brief    : Self-checking bench for note_scheduler (16-cycle beats, 8-cycle
//            window, 4 beats, 4 lanes) with a per-beat scoring model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] note_req;
  logic [3:0] lane_hit;
  logic [5:0] beat_idx;
  logic       tick_out;
  logic [3:0] should_hit;
  logic [11:0] score;
  logic [7:0] combo;
  logic       busy;
  logic       done;

  logic [3:0] pat [4];
  logic [3:0] hit [4];
  int         exp_sc [4];
  int         exp_cb [4];

  int n_checks = 0;
  int n_pass   = 0;

  note_scheduler #(
    .LANES(4), .BEAT_CYC(16), .WIN_CYC(8), .NUM_BEATS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .note_req(note_req), .lane_hit(lane_hit), .beat_idx(beat_idx),
    .tick_out(tick_out), .should_hit(should_hit), .score(score),
    .combo(combo), .busy(busy), .done(done)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  // The song chart: notes and player hits looked up by current beat.
  assign note_req = pat[beat_idx[1:0]];
  assign lane_hit = hit[beat_idx[1:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Running score/combo after each beat, straight from the scoring rules.
  function automatic void compute_model();
    int sc = 0;
    int cb = 0;
    for (int b = 0; b < 4; b++) begin
      int h = $countones(pat[b] & hit[b]);
      int m = $countones(pat[b] & ~hit[b]);
      sc = (sc + h > 4095) ? 4095 : sc + h;
      if (m > 0) cb = 0;
      else cb = (cb + h > 255) ? 255 : cb + h;
      exp_sc[b] = sc;
      exp_cb[b] = cb;
    end
  endfunction

  task automatic play_song(input int n_cyc, input bit rand_start);
    compute_model();
    @(negedge clk); start = 1'b1; stop = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int t = 0; t < n_cyc; t++) begin
      int b;
      int c;
      b = t / 16;
      c = t % 16;
      chk("busy", busy, 1);
      chk("done_in_play", done, 0);
      chk("tick", tick_out, (c == 0) ? 1 : 0);
      chk("beat_idx", beat_idx, b);
      chk("should_hit", should_hit, (c >= 1 && c <= 8) ? 32'(pat[b]) : 0);
      if (c == 0) begin
        chk("score_beat", score, (b == 0) ? 0 : exp_sc[b-1]);
        chk("combo_beat", combo, (b == 0) ? 0 : exp_cb[b-1]);
      end
      start = rand_start && ($urandom_range(0, 3) == 0) && (t < 63);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic end_checks();
    chk("done_end", done, 1);
    chk("busy_end", busy, 0);
    chk("beat_idx_end", beat_idx, 3);
    chk("score_end", score, exp_sc[3]);
    chk("combo_end", combo, exp_cb[3]);
    chk("should_hit_end", should_hit, 0);
    for (int k = 0; k < 5; k++) begin
      chk("tick_after_done", tick_out, 0);
      chk("done_hold", done, 1);
      @(negedge clk);
    end
  endtask

  initial begin
    for (int b = 0; b < 4; b++) begin
      pat[b] = 4'b0101;
      hit[b] = 4'b0101;
    end

    // Asynchronous reset, checked before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tick", tick_out, 0);
    chk("rst_score", score, 0);
    chk("rst_combo", combo, 0);
    chk("rst_beat", beat_idx, 0);
    chk("rst_should_hit", should_hit, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);

    // All hits every beat.
    play_song(64, 1'b0);
    end_checks();
    chk("score_full", score, 8);
    chk("combo_full", combo, 8);

    // Partial miss on beat 2.
    hit[2] = 4'b0001;
    play_song(64, 1'b0);
    end_checks();
    chk("score_miss", score, 7);
    chk("combo_miss", combo, 2);

    // Empty beat 1 leaves combo untouched.
    hit[2] = 4'b0101;
    pat[1] = 4'b0000;
    play_song(64, 1'b1);
    end_checks();
    chk("score_empty", score, 6);
    chk("combo_empty", combo, 6);

    // Start and stop together in DONE go to IDLE, holding the score.
    start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    chk("ss_done", done, 0);
    chk("ss_busy", busy, 0);
    chk("ss_tick", tick_out, 0);
    chk("ss_score", score, 6);

    // Stop during beat 1, cyc 5.
    pat[1] = 4'b0101;
    play_song(21, 1'b0);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    chk("stop_should_hit", should_hit, 0);
    for (int k = 0; k < 20; k++) begin
      chk("stop_tick", tick_out, 0);
      chk("stop_idle", busy, 0);
      chk("stop_score", score, 2);
      chk("stop_combo", combo, 2);
      @(negedge clk);
    end

    // Randomized songs, with start also chattering while playing.
    for (int s = 0; s < 4; s++) begin
      for (int b = 0; b < 4; b++) begin
        pat[b] = 4'($urandom_range(0, 15));
        hit[b] = 4'($urandom_range(0, 15));
      end
      play_song(64, 1'b1);
      end_checks();
    end

    // Reset during beat 2, cyc 9.
    for (int b = 0; b < 4; b++) begin
      pat[b] = 4'b1111;
      hit[b] = 4'b1111;
    end
    play_song(41, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tick", tick_out, 0);
    chk("mid_rst_score", score, 0);
    chk("mid_rst_combo", combo, 0);
    chk("mid_rst_beat", beat_idx, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_should_hit", should_hit, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk("post_rst_busy", busy, 0);
      chk("post_rst_tick", tick_out, 0);
      @(negedge clk);
    end

    // Fresh song after reset still works.
    play_song(64, 1'b0);
    end_checks();
    chk("score_after_rst", score, 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
